booth_mult: RTL

Sequential radix-2 Booth multiplier for the CPU's MULT/MULTU path, sitting beside the iterative divider in the execute stage. It uses the same start/busy handshake as the divider, so the pipeline stall logic treats both units identically. It accepts two WIDTH-bit operands and produces a 2·WIDTH-bit product after WIDTH+1 iteration cycles. Signed and unsigned modes share one datapath via a one-bit operand extension.

---
 rtl/booth_pkg.sv | 24 ++
 rtl/booth_step.sv | 34 +++
 rtl/booth_mult.sv | 120 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared multiply/divide definitions: default width, iteration count, FSM states, Booth select codes.
// Latency: n/a (package).
// Backpressure: n/a (package).
package booth_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int ITER_DEF  = WIDTH_DEF + 1;
   localparam int CNT_W_DEF = $clog2(ITER_DEF + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // {Q[0], Q-1} patterns that trigger an add or subtract of M
   localparam logic [1:0] SEL_ADD = 2'b01;
   localparam logic [1:0] SEL_SUB = 2'b10;

   // Counter width for a given operand width (iterations = width + 1, plus terminal value)
   function automatic int cnt_width(input int width);
      return $clog2(width + 2);
   endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then arithmetic right shift of {A,Q,Q-1}.
// Latency: purely combinational.
// Backpressure: none.
// Ports: acc_i/q_i/qm1_i current state, m_i extended multiplicand; acc_o/q_o/qm1_o next state.
module booth_step
   import booth_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH:0] acc_i,
   input  logic [WIDTH:0] q_i,
   input  logic           qm1_i,
   input  logic [WIDTH:0] m_i,
   output logic [WIDTH:0] acc_o,
   output logic [WIDTH:0] q_o,
   output logic           qm1_o
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = acc_i;
      case ({q_i[0], qm1_i})
         SEL_ADD: sum = acc_i + m_i;
         SEL_SUB: sum = acc_i - m_i;
         default: sum = acc_i;
      endcase
      // Arithmetic shift: A's MSB is replicated, A's LSB moves into Q's MSB
      acc_o = {sum[WIDTH], sum[WIDTH:1]};
      q_o   = {sum[0], q_i[WIDTH:1]};
      qm1_o = q_i[0];
   end

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier (signed/unsigned) for MULT/MULTU.
// Latency: WIDTH+1 cycles from accepting edge to z valid with done pulse.
// Backpressure: start is ignored while busy; caller holds start until busy seen high.
// Ports: clk, rst (async active-low), a/b operands, is_signed mode, start request;
//        z product (held until next completion), busy, done (one-cycle pulse).
module booth_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   input  logic               start,
   output logic [2*WIDTH-1:0] z,
   output logic               busy,
   output logic               done
);

   localparam int ITER  = WIDTH + 1;
   localparam int CNT_W = cnt_width(WIDTH);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH:0]     acc_q, acc_d;
   logic [WIDTH:0]     q_q, q_d;
   logic               qm1_q, qm1_d;
   logic [WIDTH:0]     m_q, m_d;
   logic [2*WIDTH-1:0] z_q, z_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [WIDTH:0]     a_ext, b_ext;
   logic [WIDTH:0]     acc_nxt, q_nxt;
   logic               qm1_nxt;

   // One extra operand bit lets unsigned operands run through the signed datapath
   assign a_ext = {is_signed & a[WIDTH-1], a};
   assign b_ext = {is_signed & b[WIDTH-1], b};

   booth_step #(.WIDTH(WIDTH)) u_step (
      .acc_i (acc_q),
      .q_i   (q_q),
      .qm1_i (qm1_q),
      .m_i   (m_q),
      .acc_o (acc_nxt),
      .q_o   (q_nxt),
      .qm1_o (qm1_nxt)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      m_d     = m_q;
      z_d     = z_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               m_d     = a_ext;
               acc_d   = '0;
               q_d     = b_ext;
               qm1_d   = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_nxt;
            q_d   = q_nxt;
            qm1_d = qm1_nxt;
            cnt_d = cnt_q + 1'b1;
            // Last step: the product is the low 2*WIDTH bits of {A,Q} after this shift
            if (cnt_q == CNT_W'(ITER - 1)) begin
               z_d     = {acc_nxt[WIDTH-2:0], q_nxt};
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         m_q     <= '0;
         z_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         m_q     <= m_d;
         z_q     <= z_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign z    = z_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
